ysyx_24090003_lsu: RTL

//  Load/store unit: the memory-side consumer of the decoder's mem_en/mem_we/mem_width/mem_unsigned controls.

---
 rtl/ysyx_24090003_lsu_pkg.sv | 24 ++
 rtl/ysyx_24090003_lsu_if.sv | 15 +
 rtl/ysyx_24090003_lsu_align.sv | 47 ++++
 rtl/ysyx_24090003_lsu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ysyx_24090003_lsu_pkg.sv
// Shared width codes, FSM state encoding and the alignment predicate for the load/store unit.
package ysyx_24090003_lsu_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Width code 2'b11 is handled like a word everywhere, including here.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      MEM_W_BYTE: return 1'b0;
      MEM_W_HALF: return off[0];
      default:    return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_if.sv
// Word-wide data bus between the LSU (master) and memory (slave): one request, one response.
interface ysyx_24090003_lsu_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output valid, addr, we, wstrb, wdata, input ready, rvalid, rdata, err);
  modport slave  (input valid, addr, we, wstrb, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/ysyx_24090003_lsu_align.sv
// Combinational byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module ysyx_24090003_lsu_align
  import ysyx_24090003_lsu_pkg::*;
(
  input  logic [1:0]  i_st_width,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_width,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [15:0] w_shifted;

  // Strobe shifts are evaluated in 4 bits, so lanes past byte 3 simply fall off.
  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_st_wdata;
    case (i_st_width)
      MEM_W_BYTE: begin
        o_wstrb = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_wdata[7:0]}};
      end
      MEM_W_HALF: begin
        o_wstrb = 4'b0011 << i_st_off;
        o_wdata = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = 16'(i_ld_rdata >> {i_ld_off, 3'b000});

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_width)
      MEM_W_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      MEM_W_HALF: o_ld_data = {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_24090003_lsu.sv
// Load/store unit: one request -> one bus transaction -> one response. Define LSU_MISALIGN_TRAP_EN
// to reject misaligned half/word accesses without touching the bus.
module ysyx_24090003_lsu
  import ysyx_24090003_lsu_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [1:0]  i_width,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_misalign,
  ysyx_24090003_lsu_if.master io_bus
);

  // Counter only needs to reach RESP_TIMEOUT-1.
  localparam int unsigned CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  lsu_state_e       r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             r_misalign;
  logic             r_bus_valid;
  logic [31:0]      r_bus_addr;
  logic             r_bus_we;
  logic [3:0]       r_bus_wstrb;
  logic [31:0]      r_bus_wdata;
  logic [1:0]       r_width;
  logic [1:0]       r_off;
  logic             r_unsigned;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic        w_misalign;

  ysyx_24090003_lsu_align u_align (
    .i_st_width    (i_width),
    .i_st_off      (i_addr[1:0]),
    .i_st_wdata    (i_wdata),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .i_ld_width    (r_width),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (io_bus.rdata),
    .o_ld_data     (w_ld_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(i_width, i_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= LSU_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_wstrb <= '0;
      r_bus_wdata <= '0;
      r_width     <= MEM_W_BYTE;
      r_off       <= '0;
      r_unsigned  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_width     <= i_width;
            r_off       <= i_addr[1:0];
            r_unsigned  <= i_unsigned;
            r_rdata     <= '0;
            r_err       <= w_misalign;
            r_misalign  <= w_misalign;
            if (w_misalign) begin
              r_rsp_valid <= 1'b1;
              r_state     <= LSU_DONE;
            end else begin
              r_bus_valid <= 1'b1;
              r_bus_addr  <= {i_addr[31:2], 2'b00};
              r_bus_we    <= i_we;
              r_bus_wstrb <= w_wstrb;
              r_bus_wdata <= w_wdata;
              r_state     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          // Any rvalid seen before the request handshake is stray and dropped.
          if (io_bus.ready) begin
            r_bus_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (io_bus.rvalid) begin
            r_err       <= io_bus.err;
            r_rdata     <= (io_bus.err || r_bus_we) ? 32'h0 : w_ld_data;
            r_rsp_valid <= 1'b1;
            r_state     <= LSU_DONE;
          end else if ((RESP_TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_err       <= 1'b1;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= LSU_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_DONE: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= LSU_IDLE;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rdata       = r_rdata;
  assign o_err         = r_err;
  assign o_misalign    = r_misalign;
  assign io_bus.valid  = r_bus_valid;
  assign io_bus.addr   = r_bus_addr;
  assign io_bus.we     = r_bus_we;
  assign io_bus.wstrb  = r_bus_wstrb;
  assign io_bus.wdata  = r_bus_wdata;

endmodule
